hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common 7-segment display. It shares one segment bus across N digit enables. A valid/ready port loads new digit values, which are committed only at frame boundaries so the display never tears. Blank guard intervals between digits suppress ghosting. It sits between the counter/datapath logic and the board's hex/digit pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 50_000, clock cycles per digit slot, including blank time
BLANK_CYC, 500, leading blank cycles per slot; must satisfy 1 <= BLANK_CYC < SCAN_DIV

Ports:
clk  input  1  system clock
key  input  1  asynchronous active-low reset
enable  input  1  scan enable; 0 forces display off
load_valid  input  1  new frame data offered
load_ready  output  1  controller can accept data
load_data  input  4*N_DIGITS  nibble i = hex value for digit i
load_dp  input  N_DIGITS  bit i = decimal point for digit i
seg  output  8  segments, active-high: seg[7:1]=a..g, seg[0]=dp
dig  output  N_DIGITS  one-hot active-high digit enable
frame_tick  output  1  one-cycle pulse at each frame boundary (commit point)

Behaviour:
- Clock and reset: one clock (clk). Reset (key) is asynchronous and active-low. While key=0: seg=0, dig=0, frame_tick=0, load_ready=1; active/pending registers = 0; idx=0; slot counter=0; pending_flag=0; state=OFF.
- All outputs are registered.
- State OFF (enable=0):
  - dig=0, seg=0, counters held at 0.
  - If pending_flag=1, commit pending->active on the next cycle.
  - If enable=1, go to BLANK with idx=0 on the next cycle.
- State BLANK:
  - dig=0; seg=decode(active[idx]) so segments settle before enable.
  - Slot counter counts 0..BLANK_CYC-1, then goes to SHOW.
- State SHOW:
  - dig=1<<idx; seg=decode(active[idx]) | dp[idx].
  - Slot counter continues to SCAN_DIV-1.
  - At SCAN_DIV-1: counter=0, idx=idx+1, go to BLANK.
  - Each slot is exactly SCAN_DIV cycles; dig is high for SCAN_DIV-BLANK_CYC cycles.
- Frame boundary: the last SHOW cycle with idx=N_DIGITS-1.
  - idx wraps to 0.
  - Next cycle: frame_tick=1 for one cycle; if pending_flag=1, active<=pending and pending_flag clears in that same cycle.
- enable falling in any state: next cycle state=OFF, dig=0, seg=0, idx=0, no frame_tick.
- Re-enable: first dig[0] assertion occurs BLANK_CYC+1 cycles after the enable-high edge.
- Handshake:
  - Transfer occurs on a cycle where load_valid=1 and load_ready=1.
  - On transfer: data and dp captured into pending; pending_flag=1; load_ready=0 from the next cycle.
  - load_ready returns to 1 the cycle after commit.
  - load_valid while load_ready=0 has no effect; the source must hold its data.
- Simultaneous transfer and frame boundary: the data stays pending and commits at the following boundary, never the current one.
- Decode (abcdefg, before the <<1 shift):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - Resulting seg bytes without dp: 0=FC, 1=60, 8=FE, F=8E.
- Widths:
  - slot counter = $clog2(SCAN_DIV)
  - idx = $clog2(N_DIGITS), minimum 1 bit
  - the counter must never exceed SCAN_DIV-1
- Reset mid-frame: immediate return to the reset values; pending data is discarded.

Decomposition:
- Package hex_disp_pkg:
  - typedef scan_state_t {OFF, BLANK, SHOW}
  - SEG_BLANK=8'h00
  - function/constant table for the 16 segment codes
- Sub-module hex_seg_decode: combinational 4-bit value + dp -> 8-bit seg. Instantiated once.

Test Plan:
- Reset/enable (N=4, SCAN_DIV=8, BLANK_CYC=2): key=0 -> seg=0, dig=0, load_ready=1; enable=1 at cycle 0 -> dig=0001 at cycle 3, held 6 cycles; 1 cycle... then dig=0 for 2 cycles, then 0010.
- Load: load_data=16'h3210, load_dp=4'b0001 while enabled -> load_ready=0 next cycle; frame_tick 1 cycle after the idx-3 slot ends; load_ready=1 the cycle after; then digit 0 seg=FD, digit 1=60, digit 2=DA, digit 3=F2.
- No tearing: load 16'hFFFF mid-frame (idx=1) -> digits 1..3 keep their old values for the rest of that frame; all show 8E only after frame_tick.
- Collision: load_valid asserted on the boundary cycle -> the current frame_tick does not commit; commit occurs at the next frame_tick (4*8 cycles later).
- enable dropped during SHOW idx=2 -> next cycle dig=0, seg=0, no frame_tick; pending data commits in OFF; re-enable restarts at dig=0001.
- Async reset mid-SHOW with pending data -> outputs return to reset values without a clock edge; after release, load_ready=1 and all digits show FC.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment scan controller.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // abcdefg, a in the MSB
    function automatic logic [6:0] seg_code(input logic [3:0] i_val);
        logic [6:0] w_code;
        case (i_val)
            4'h0:    w_code = 7'h7E;
            4'h1:    w_code = 7'h30;
            4'h2:    w_code = 7'h6D;
            4'h3:    w_code = 7'h79;
            4'h4:    w_code = 7'h33;
            4'h5:    w_code = 7'h5B;
            4'h6:    w_code = 7'h5F;
            4'h7:    w_code = 7'h70;
            4'h8:    w_code = 7'h7F;
            4'h9:    w_code = 7'h7B;
            4'hA:    w_code = 7'h77;
            4'hB:    w_code = 7'h1F;
            4'hC:    w_code = 7'h4E;
            4'hD:    w_code = 7'h3D;
            4'hE:    w_code = 7'h4F;
            default: w_code = 7'h47;
        endcase
        return w_code;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble plus decimal point to active-high segment byte {a..g, dp}.
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = {seg_code(i_val), i_dp};
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with frame-synchronous data commit
// and a blank guard interval at the start of every digit slot.
module hex_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic                  i_clk,
    input  logic                  i_key,
    input  logic                  i_enable,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [4*N_DIGITS-1:0] i_load_data,
    input  logic [N_DIGITS-1:0]   i_load_dp,
    output logic [7:0]            o_seg,
    output logic [N_DIGITS-1:0]   o_dig,
    output logic                  o_frame_tick
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = idx_width(N_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    scan_state_t           r_state, w_state_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic [IDX_W-1:0]      r_idx, w_idx_d;

    logic [4*N_DIGITS-1:0] r_active, w_active_d;
    logic [N_DIGITS-1:0]   r_active_dp, w_active_dp_d;
    logic [4*N_DIGITS-1:0] r_pend_data;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic                  r_pend;
    logic                  r_load_ready;

    logic [7:0]            r_seg;
    logic [N_DIGITS-1:0]   r_dig;
    logic                  r_frame_tick;

    logic                  w_transfer;
    logic                  w_boundary;
    logic                  w_commit;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_show;
    logic [7:0]            w_seg;

    always_comb begin
        w_transfer = i_load_valid & r_load_ready;
        w_boundary = (r_state == SHOW) && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
        // A transfer on the boundary cycle sees r_pend=0, so it waits for the next frame.
        w_commit   = r_pend && ((r_state == OFF) || (w_boundary && i_enable));
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        if (!i_enable) begin
            w_state_d = OFF;
            w_cnt_d   = '0;
            w_idx_d   = '0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_d = BLANK;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end
                BLANK: begin
                    w_cnt_d = r_cnt + 1'b1;
                    if (r_cnt == BLANK_LAST) begin
                        w_state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_d = BLANK;
                        w_cnt_d   = '0;
                        w_idx_d   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_d = OFF;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_active_d    = w_commit ? r_pend_data : r_active;
        w_active_dp_d = w_commit ? r_pend_dp : r_active_dp;
        w_show        = (w_state_d == SHOW);
        w_nib         = 4'h0;
        w_dp_sel      = 1'b0;
        // Outputs are registered from next-state values so they track the state with no lag.
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_idx_d == IDX_W'(i)) begin
                w_nib    = w_active_d[4*i +: 4];
                w_dp_sel = w_active_dp_d[i];
            end
        end
    end

    hex_seg_decode u_seg_decode (
        .i_val (w_nib),
        .i_dp  (w_show & w_dp_sel),
        .o_seg (w_seg)
    );

    always_ff @(posedge i_clk or negedge i_key) begin
        if (!i_key) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_key) begin
        if (!i_key) begin
            r_active     <= '0;
            r_active_dp  <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_active     <= w_active_d;
            r_active_dp  <= w_active_dp_d;
            r_load_ready <= w_transfer ? 1'b0 : ~r_pend;
            if (w_transfer) begin
                r_pend_data <= i_load_data;
                r_pend_dp   <= i_load_dp;
                r_pend      <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_key) begin
        if (!i_key) begin
            r_seg        <= SEG_BLANK;
            r_dig        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= (w_state_d == OFF) ? SEG_BLANK : w_seg;
            r_dig        <= w_show ? (N_DIGITS'(1) << w_idx_d) : '0;
            r_frame_tick <= w_boundary & i_enable;
        end
    end

    assign o_seg        = r_seg;
    assign o_dig        = r_dig;
    assign o_frame_tick = r_frame_tick;
    assign o_load_ready = r_load_ready;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: a time-position reference model predicts every cycle.
module tb_hex_scan_ctrl;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SD;

    logic          clk = 1'b0;
    logic          key = 1'b0;
    logic          enable = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [15:0]   load_data = '0;
    logic [3:0]    load_dp = '0;
    logic [7:0]    seg;
    logic [3:0]    dig;
    logic          frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: scan position is plain elapsed-cycle arithmetic since enable.
    bit         m_run;
    int         m_t;
    int         m_act [N];
    bit         m_adp [N];
    bit         m_pend;
    int         m_pdat [N];
    bit         m_pdp [N];
    bit         m_ready;
    bit         m_tick;
    logic [7:0] m_seg;
    logic [3:0] m_dig;

    hex_scan_ctrl #(
        .N_DIGITS  (N),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .i_clk        (clk),
        .i_key        (key),
        .i_enable     (enable),
        .i_load_valid (load_valid),
        .o_load_ready (load_ready),
        .i_load_data  (load_data),
        .i_load_dp    (load_dp),
        .o_seg        (seg),
        .o_dig        (dig),
        .o_frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code7(input int v);
        case (v)
            0: return 7'h7E;   1: return 7'h30;   2: return 7'h6D;   3: return 7'h79;
            4: return 7'h33;   5: return 7'h5B;   6: return 7'h5F;   7: return 7'h70;
            8: return 7'h7F;   9: return 7'h7B;   10: return 7'h77;  11: return 7'h1F;
            12: return 7'h4E;  13: return 7'h3D;  14: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic int cur_d();
        return (m_t / SD) % N;
    endfunction

    function automatic int cur_pos();
        return m_t % SD;
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_pend = 0; m_ready = 1; m_tick = 0;
        m_seg = 8'h00; m_dig = 4'h0;
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_adp[i] = 0; m_pdat[i] = 0; m_pdp[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit xfer, tick, commit, old_pend;
        int d, pos;
        xfer     = load_valid && m_ready;
        tick     = enable && m_run && (m_t % FRAME == FRAME - 1);
        commit   = m_pend && (!m_run || tick);
        old_pend = m_pend;
        if (commit) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = m_pdat[i];
                m_adp[i] = m_pdp[i];
            end
            m_pend = 0;
        end
        if (xfer) begin
            for (int i = 0; i < N; i++) begin
                m_pdat[i] = int'(load_data[4*i +: 4]);
                m_pdp[i]  = load_dp[i];
            end
            m_pend = 1;
        end
        m_ready = xfer ? 1'b0 : !old_pend;
        m_tick  = tick;
        if (enable) begin
            m_t   = m_run ? m_t + 1 : 0;
            m_run = 1;
        end else begin
            m_t   = 0;
            m_run = 0;
        end
        if (!m_run) begin
            m_seg = 8'h00;
            m_dig = 4'h0;
        end else begin
            d     = cur_d();
            pos   = cur_pos();
            m_dig = (pos >= BC) ? (4'b0001 << d) : 4'b0000;
            m_seg = {code7(m_act[d]), (pos >= BC) && m_adp[d]};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Steps (unchecked) until the model sits at digit d / position pos.
    task automatic seek(input int d, input int pos, input string tag);
        int n = 0;
        while (!(m_run && cur_d() == d && cur_pos() == pos) && n < 4 * FRAME) begin
            step();
            n++;
        end
        if (n >= 4 * FRAME) begin
            n_checks++; n_errors++;
            $display("FAIL %s_seek: position d=%0d pos=%0d not reached, required d=%0d pos=%0d",
                     tag, cur_d(), cur_pos(), d, pos);
        end
    endtask

    task automatic load_once(input logic [15:0] data, input logic [3:0] dp);
        load_valid = 1'b1; load_data = data; load_dp = dp;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        key = 1'b0; enable = 1'b0; load_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({seg, dig, frame_tick, load_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset: seg=%h dig=%b tick=%b ready=%b, required 00 0000 0 1",
                     seg, dig, frame_tick, load_ready);
        end
        key = 1'b1;
        step();
    endtask

    task automatic test_enable();
        enable = 1'b1;
        for (int c = 1; c <= 3 * FRAME; c++) begin
            step();
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL enable c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b", c,
                         seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
            if (c == 3) begin
                n_checks++;
                if (dig !== 4'b0001) begin
                    n_errors++;
                    $display("FAIL first_dig: dig=%b, required 0001", dig);
                end
            end
        end
    endtask

    task automatic test_load();
        load_once(16'h3210, 4'b0001);
        for (int c = 0; c < 2 * FRAME + 8; c++) begin
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL load c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b", c,
                         seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
            step();
        end
    endtask

    task automatic test_no_tear();
        seek(1, BC, "no_tear");
        load_once(16'hFFFF, 4'b0000);
        for (int c = 0; c < 2 * FRAME; c++) begin
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL no_tear c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b", c,
                         seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
            step();
        end
    endtask

    task automatic test_collision();
        seek(N - 1, SD - 1, "collision");
        load_once(16'hA5C7, 4'b1010);
        n_checks++;
        if ({frame_tick, seg} !== {1'b1, 8'h8E}) begin
            n_errors++;
            $display("FAIL collision_hold: tick=%b seg=%h, required 1 8e", frame_tick, seg);
        end
        for (int c = 0; c < FRAME + 8; c++) begin
            step();
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL collision c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b", c,
                         seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
        end
    endtask

    task automatic test_enable_drop();
        seek(2, BC, "drop");
        load_once(16'h4321, 4'b0100);
        enable = 1'b0;
        for (int c = 0; c < FRAME + 8; c++) begin
            if (c == 4) enable = 1'b1;
            step();
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL drop c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b", c,
                         seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
        end
    endtask

    task automatic test_async_reset();
        seek(1, BC + 1, "areset");
        load_once(16'h9999, 4'b1111);
        #2 key = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({seg, dig, frame_tick, load_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL async_reset: seg=%h dig=%b tick=%b ready=%b, required 00 0000 0 1",
                     seg, dig, frame_tick, load_ready);
        end
        @(negedge clk);
        key = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            step();
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL post_reset c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b",
                         c, seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
        end
    endtask

    task automatic test_random();
        bit xfer;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 2) enable = ~enable;
            if (!load_valid && $urandom_range(99) < 10) begin
                load_valid = 1'b1;
                load_data  = 16'($urandom);
                load_dp    = 4'($urandom);
            end
            xfer = load_valid && m_ready;
            step();
            if (xfer) load_valid = 1'b0;
            n_checks++;
            if ({seg, dig, frame_tick, load_ready} !== {m_seg, m_dig, m_tick, m_ready}) begin
                n_errors++;
                $display("FAIL random c%0d: seg=%h dig=%b tick=%b rdy=%b, req %h %b %b %b", c,
                         seg, dig, frame_tick, load_ready, m_seg, m_dig, m_tick, m_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_load();
        test_no_tear();
        test_collision();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
